// File: rtl/dht11_sched_ctrl.sv
// dht11_sched_ctrl: register-mapped measurement scheduler for a DHT11 receiver core.
// Starts measurements on command or periodically, enforces the sensor's minimum spacing
// between start pulses, times out silent sensors and validates the checksum.
// Optional feature macro: DHT11_SCHED_RETRY_EN -- when defined, a failed attempt is
// retried up to MAX_RETRY times; otherwise the first failure is final.
module dht11_sched_ctrl #(
  parameter int unsigned GAP_CYC     = 200_000_000,
  parameter int unsigned TIMEOUT_CYC = 5_000_000,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        sensor_start,
  input  logic        sensor_done,
  input  logic [7:0]  hum_int,
  input  logic [7:0]  hum_dec,
  input  logic [7:0]  tem_int,
  input  logic [7:0]  tem_dec,
  input  logic [7:0]  checksum,
  output logic        irq
);

`ifdef DHT11_SCHED_RETRY_EN
  localparam logic RETRY_EN = 1'b1;
`else
  localparam logic RETRY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, START, WAIT, CHECK, GAP} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  ctrl_reg;              // bit0 AUTO_EN, bit1 IRQ_EN
  logic [31:0] period_reg;
  logic [31:0] data_reg;
  logic [15:0] count_reg;
  logic        valid_reg, cks_err_reg, timeout_reg;
  logic [1:0]  retries_stat_reg;      // retries used by the last finished measurement
  logic [1:0]  retry_cnt_reg;         // retries used by the measurement in flight
  logic        retry_go_reg;          // GAP is followed by another attempt
  logic        fail_to_reg;           // attempt ended by timeout rather than done
  logic        pending_reg;
  logic [31:0] idle_cnt_reg, gap_cnt_reg, to_cnt_reg;
  logic [7:0]  s_hi_reg, s_hd_reg, s_ti_reg, s_td_reg, s_ck_reg;

  logic        launch, take_sample, pass_evt, fail_evt, can_retry;
  logic        auto_due, gap_done, timed_out, busy;
  logic [7:0]  sum_c;
  logic [2:0]  sel;
  logic        wr_en, ctrl_wr, cmd_wr, stat_wr, period_wr;
  logic        unused_addr_bits;

  assign sel       = addr[4:2];
  assign wr_en     = cs & wr;
  assign ctrl_wr   = wr_en && (sel == 3'd0);
  assign cmd_wr    = wr_en && (sel == 3'd1) && wdata[0];
  assign stat_wr   = wr_en && (sel == 3'd2);
  assign period_wr = wr_en && (sel == 3'd4);
  assign unused_addr_bits = ^{addr[31:5], addr[1:0]};

  assign busy      = (state_reg != IDLE);
  assign sum_c     = s_hi_reg + s_hd_reg + s_ti_reg + s_td_reg;
  // Idle timer counts from 0 on IDLE entry, so START lands PERIOD cycles after entry.
  assign auto_due  = ({1'b0, idle_cnt_reg} + 33'd1) >= {1'b0, period_reg};
  // gap_cnt_reg holds cycles since the last start pulse; leave GAP one cycle early so
  // the next pulse sits exactly GAP_CYC after the previous one.
  assign gap_done  = ({1'b0, gap_cnt_reg} + 33'd1) >= 33'(GAP_CYC);
  assign timed_out = to_cnt_reg >= TIMEOUT_CYC;
  assign can_retry = RETRY_EN && (32'(retry_cnt_reg) < MAX_RETRY);
  assign irq       = ctrl_reg[1] & (valid_reg | cks_err_reg | timeout_reg);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic and per-state strobes.
  always_comb begin
    state_next   = state_reg;
    sensor_start = 1'b0;
    launch       = 1'b0;
    take_sample  = 1'b0;
    pass_evt     = 1'b0;
    fail_evt     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pending_reg || (ctrl_reg[0] && auto_due)) begin
          launch     = 1'b1;
          state_next = START;
        end
      end
      START: begin
        sensor_start = 1'b1;
        state_next   = WAIT;
      end
      WAIT: begin
        // done is checked first so it wins over a coincident timeout
        if (sensor_done) begin
          take_sample = 1'b1;
          state_next  = CHECK;
        end else if (timed_out) begin
          state_next  = CHECK;
        end
      end
      CHECK: begin
        if (!fail_to_reg && (sum_c == s_ck_reg)) pass_evt = 1'b1;
        else                                     fail_evt = 1'b1;
        state_next = GAP;
      end
      GAP: begin
        if (gap_done) state_next = retry_go_reg ? START : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Counters, captured sensor bytes and the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_reg         <= '0;
      period_reg       <= '0;
      data_reg         <= '0;
      count_reg        <= '0;
      valid_reg        <= 1'b0;
      cks_err_reg      <= 1'b0;
      timeout_reg      <= 1'b0;
      retries_stat_reg <= '0;
      retry_cnt_reg    <= '0;
      retry_go_reg     <= 1'b0;
      fail_to_reg      <= 1'b0;
      pending_reg      <= 1'b0;
      idle_cnt_reg     <= '0;
      gap_cnt_reg      <= '0;
      to_cnt_reg       <= '0;
      s_hi_reg         <= '0;
      s_hd_reg         <= '0;
      s_ti_reg         <= '0;
      s_td_reg         <= '0;
      s_ck_reg         <= '0;
    end else begin
      if (ctrl_wr)   ctrl_reg   <= wdata[1:0];
      if (period_wr) period_reg <= wdata;

      // A request raised while one is being launched stays pending (set wins).
      if (cmd_wr)      pending_reg <= 1'b1;
      else if (launch) pending_reg <= 1'b0;

      if (state_reg != IDLE)      idle_cnt_reg <= '0;
      else if (~&idle_cnt_reg)    idle_cnt_reg <= idle_cnt_reg + 32'd1;

      if (sensor_start)           gap_cnt_reg <= 32'd1;
      else if (~&gap_cnt_reg)     gap_cnt_reg <= gap_cnt_reg + 32'd1;

      if (state_reg == START)     to_cnt_reg <= '0;
      else if (state_reg == WAIT) to_cnt_reg <= to_cnt_reg + 32'd1;

      if (state_reg == WAIT) begin
        if (sensor_done)    fail_to_reg <= 1'b0;
        else if (timed_out) fail_to_reg <= 1'b1;
      end

      if (take_sample) begin
        s_hi_reg <= hum_int;
        s_hd_reg <= hum_dec;
        s_ti_reg <= tem_int;
        s_td_reg <= tem_dec;
        s_ck_reg <= checksum;
      end

      if (launch)                      retry_cnt_reg <= '0;
      else if (fail_evt && can_retry)  retry_cnt_reg <= retry_cnt_reg + 2'd1;

      if (pass_evt)      retry_go_reg <= 1'b0;
      else if (fail_evt) retry_go_reg <= can_retry;

      if (pass_evt || (fail_evt && !can_retry)) retries_stat_reg <= retry_cnt_reg;

      if (pass_evt) begin
        data_reg  <= {s_hi_reg, s_hd_reg, s_ti_reg, s_td_reg};
        count_reg <= count_reg + 16'd1;
      end

      // Status flags: hardware set has priority over a write-1-to-clear.
      if (pass_evt)                   valid_reg <= 1'b1;
      else if (stat_wr && wdata[0])   valid_reg <= 1'b0;

      if (fail_evt && !can_retry && !fail_to_reg) cks_err_reg <= 1'b1;
      else if (pass_evt || (stat_wr && wdata[2])) cks_err_reg <= 1'b0;

      if (fail_evt && !can_retry && fail_to_reg)  timeout_reg <= 1'b1;
      else if (pass_evt || (stat_wr && wdata[3])) timeout_reg <= 1'b0;
    end
  end

  // Combinational register read.
  always_comb begin
    rdata = '0;
    case (sel)
      3'd0: rdata = {30'd0, ctrl_reg};
      3'd2: rdata = {26'd0, retries_stat_reg, timeout_reg, cks_err_reg, busy, valid_reg};
      3'd3: rdata = data_reg;
      3'd4: rdata = period_reg;
      3'd5: rdata = {16'd0, count_reg};
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_dht11_sched_ctrl.sv
// Directed testbench for dht11_sched_ctrl (GAP_CYC=100, TIMEOUT_CYC=50, MAX_RETRY=2).
// Expectations follow DHT11_SCHED_RETRY_EN the same way the design does.
module tb_dht11_sched_ctrl;

`ifdef DHT11_SCHED_RETRY_EN
  localparam bit RETRY_ON = 1'b1;
`else
  localparam bit RETRY_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        sensor_start;
  logic        sensor_done = 1'b0;
  logic [7:0]  hum_int = '0, hum_dec = '0, tem_int = '0, tem_dec = '0, checksum = '0;
  logic        irq;

  dht11_sched_ctrl #(.GAP_CYC(100), .TIMEOUT_CYC(50), .MAX_RETRY(2)) dut (
    .clk(clk), .rst(rst), .cs(cs), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata),
    .sensor_start(sensor_start), .sensor_done(sensor_done),
    .hum_int(hum_int), .hum_dec(hum_dec), .tem_int(tem_int), .tem_dec(tem_dec),
    .checksum(checksum), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks_total = 0;
  int checks_passed = 0;
  int exp_count = 0;

  // Start-pulse monitor: cycle index of every pulse, and any pulse longer than one cycle.
  int cyc = 0;
  int start_cnt = 0;
  int start_cyc [64];
  int long_pulse = 0;
  logic prev_start = 1'b0;
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (sensor_start) begin
      if (start_cnt < 64) start_cyc[start_cnt] = cyc;
      start_cnt = start_cnt + 1;
      if (prev_start) long_pulse = long_pulse + 1;
    end
    prev_start = sensor_start;
  end

  // Sensor model: answers each start pulse after resp_delay cycles (0 = never answers).
  // Attempts numbered below resp_bad_until get a wrong checksum.
  int resp_delay = 0;
  int resp_attempt = 0;
  int resp_bad_until = 0;
  logic [7:0] r_hi = '0, r_hd = '0, r_ti = '0, r_td = '0, r_ck = '0;
  bit resp_bad;
  always begin
    @(posedge clk);
    if (sensor_start && resp_delay > 0) begin
      resp_bad = (resp_attempt < resp_bad_until);
      resp_attempt = resp_attempt + 1;
      repeat (resp_delay - 1) @(posedge clk);
      #1;
      hum_int = r_hi; hum_dec = r_hd; tem_int = r_ti; tem_dec = r_td;
      checksum = resp_bad ? 8'd0 : r_ck;
      sensor_done = 1'b1;
      @(posedge clk);
      #1;
      sensor_done = 1'b0;
    end
  end

  task automatic wr_reg(input logic [2:0] w, input logic [31:0] d);
    cs = 1'b1; wr = 1'b1; addr = {27'd0, w, 2'b00}; wdata = d;
    @(posedge clk); #1;
    cs = 1'b0; wr = 1'b0; wdata = '0;
  endtask

  task automatic rd_reg(input logic [2:0] w, output logic [31:0] d);
    cs = 1'b1; wr = 1'b0; addr = {27'd0, w, 2'b00};
    #1;
    d = rdata;
    cs = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output bit ok, output int at_cyc);
    logic [31:0] d;
    ok = 1'b0;
    at_cyc = 0;
    for (int i = 0; i < limit; i++) begin
      rd_reg(3'd2, d);
      if (!d[1]) begin
        ok = 1'b1;
        at_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic set_resp(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input logic [7:0] e, input logic [7:0] k, input int dly);
    r_hi = a; r_hd = b; r_ti = c; r_td = e; r_ck = k; resp_delay = dly;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int w = 0; w < 8; w++) begin
      rd_reg(3'(w), d);
      checks_total++;
      if (d !== 32'd0) $display("FAIL reset_reg%0d: got 0x%08h, want 0x00000000", w, d);
      else checks_passed++;
    end
    checks_total++;
    if (irq !== 1'b0 || sensor_start !== 1'b0)
      $display("FAIL reset_outputs: irq=%b start=%b, want 0/0", irq, sensor_start);
    else checks_passed++;
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic [31:0] d;
    bit ok;
    int t, base;
    base = start_cnt;
    set_resp(8'd40, 8'd0, 8'd25, 8'd3, 8'd68, 20);
    resp_bad_until = resp_attempt;
    wr_reg(3'd1, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    wait_idle(400, ok, t);
    checks_total++;
    if (!ok) $display("FAIL single_idle: BUSY still 1 after 400 cycles, want 0");
    else checks_passed++;
    exp_count = exp_count + 1;
    rd_reg(3'd3, d);
    checks_total++;
    if (d !== 32'h28001903) $display("FAIL single_data: got 0x%08h, want 0x28001903", d);
    else checks_passed++;
    rd_reg(3'd2, d);
    checks_total++;
    if (d[5:0] !== 6'b000001) $display("FAIL single_status: got 0x%02h, want 0x01", d[5:0]);
    else checks_passed++;
    rd_reg(3'd5, d);
    checks_total++;
    if (d !== 32'(exp_count)) $display("FAIL single_count: got %0d, want %0d", d, exp_count);
    else checks_passed++;
    rd_reg(3'd1, d);
    checks_total++;
    if (d !== 32'd0) $display("FAIL single_cmd_read: got 0x%08h, want 0", d);
    else checks_passed++;
    checks_total++;
    if (start_cnt - base !== 1) $display("FAIL single_starts: got %0d, want 1", start_cnt - base);
    else checks_passed++;
    $display("test_single done: starts=%0d", start_cnt - base);
  endtask

  task automatic test_irq();
    wr_reg(3'd0, 32'd2);
    checks_total++;
    if (irq !== 1'b1) $display("FAIL irq_on_valid: got %b, want 1", irq);
    else checks_passed++;
    wr_reg(3'd2, 32'd1);
    checks_total++;
    if (irq !== 1'b0) $display("FAIL irq_after_w1c: got %b, want 0", irq);
    else checks_passed++;
    wr_reg(3'd0, 32'd0);
    $display("test_irq done");
  endtask

  task automatic test_retry_cksum();
    logic [31:0] d;
    bit ok;
    int t, base, exp_starts;
    wr_reg(3'd2, 32'hD);
    base = start_cnt;
    exp_starts = RETRY_ON ? 2 : 1;
    set_resp(8'd10, 8'd20, 8'd30, 8'd40, 8'd100, 20);
    resp_bad_until = resp_attempt + 1;
    wr_reg(3'd1, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    wait_idle(600, ok, t);
    checks_total++;
    if (!ok) $display("FAIL retry_idle: BUSY still 1 after 600 cycles, want 0");
    else checks_passed++;
    checks_total++;
    if (start_cnt - base !== exp_starts)
      $display("FAIL retry_starts: got %0d, want %0d", start_cnt - base, exp_starts);
    else checks_passed++;
    for (int i = 1; i < exp_starts; i++) begin
      checks_total++;
      if (start_cyc[base+i] - start_cyc[base+i-1] !== 100)
        $display("FAIL retry_spacing: got %0d, want 100", start_cyc[base+i] - start_cyc[base+i-1]);
      else checks_passed++;
    end
    if (RETRY_ON) exp_count = exp_count + 1;
    rd_reg(3'd2, d);
    checks_total++;
    if (d[5:0] !== (RETRY_ON ? 6'b010001 : 6'b000100))
      $display("FAIL retry_status: got 0x%02h, want 0x%02h", d[5:0], RETRY_ON ? 6'h11 : 6'h04);
    else checks_passed++;
    rd_reg(3'd3, d);
    checks_total++;
    if (d !== (RETRY_ON ? 32'h0A141E28 : 32'h28001903))
      $display("FAIL retry_data: got 0x%08h, want 0x%08h", d, RETRY_ON ? 32'h0A141E28 : 32'h28001903);
    else checks_passed++;
    rd_reg(3'd5, d);
    checks_total++;
    if (d !== 32'(exp_count)) $display("FAIL retry_count: got %0d, want %0d", d, exp_count);
    else checks_passed++;
    $display("test_retry_cksum done: starts=%0d", start_cnt - base);
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    bit ok;
    int t, base, exp_starts;
    wr_reg(3'd2, 32'hD);
    base = start_cnt;
    exp_starts = RETRY_ON ? 3 : 1;
    resp_delay = 0;
    wr_reg(3'd1, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    wait_idle(800, ok, t);
    checks_total++;
    if (!ok) $display("FAIL timeout_idle: BUSY still 1 after 800 cycles, want 0");
    else checks_passed++;
    checks_total++;
    if (start_cnt - base !== exp_starts)
      $display("FAIL timeout_starts: got %0d, want %0d", start_cnt - base, exp_starts);
    else checks_passed++;
    for (int i = 1; i < exp_starts; i++) begin
      checks_total++;
      if (start_cyc[base+i] - start_cyc[base+i-1] !== 100)
        $display("FAIL timeout_spacing: got %0d, want 100", start_cyc[base+i] - start_cyc[base+i-1]);
      else checks_passed++;
    end
    checks_total++;
    if (t - start_cyc[base] !== (RETRY_ON ? 299 : 99))
      $display("FAIL timeout_idle_time: got %0d, want %0d", t - start_cyc[base], RETRY_ON ? 299 : 99);
    else checks_passed++;
    rd_reg(3'd2, d);
    checks_total++;
    if (d[5:0] !== (RETRY_ON ? 6'b101000 : 6'b001000))
      $display("FAIL timeout_status: got 0x%02h, want 0x%02h", d[5:0], RETRY_ON ? 6'h28 : 6'h08);
    else checks_passed++;
    $display("test_timeout done: starts=%0d", start_cnt - base);
  endtask

  task automatic test_auto();
    logic [31:0] d;
    int base, lim;
    base = start_cnt;
    set_resp(8'd1, 8'd2, 8'd3, 8'd4, 8'd10, 10);
    resp_bad_until = resp_attempt;
    wr_reg(3'd4, 32'd30);
    wr_reg(3'd0, 32'd1);
    lim = 0;
    while (start_cnt - base < 4 && lim < 800) begin
      @(posedge clk); #1;
      lim++;
    end
    wr_reg(3'd0, 32'd0);
    checks_total++;
    if (start_cnt - base < 4) $display("FAIL auto_four_starts: got %0d in 800 cycles, want 4", start_cnt - base);
    else checks_passed++;
    for (int i = 1; i < 4; i++) begin
      checks_total++;
      if (start_cyc[base+i] - start_cyc[base+i-1] !== 130)
        $display("FAIL auto_spacing%0d: got %0d, want 130", i, start_cyc[base+i] - start_cyc[base+i-1]);
      else checks_passed++;
    end
    repeat (400) @(posedge clk);
    #1;
    exp_count = exp_count + 4;
    checks_total++;
    if (start_cnt - base !== 4) $display("FAIL auto_stop: got %0d starts, want 4", start_cnt - base);
    else checks_passed++;
    rd_reg(3'd2, d);
    checks_total++;
    if (d[1:0] !== 2'b01) $display("FAIL auto_status: got busy/valid=%b, want 01", d[1:0]);
    else checks_passed++;
    rd_reg(3'd5, d);
    checks_total++;
    if (d !== 32'(exp_count)) $display("FAIL auto_count: got %0d, want %0d", d, exp_count);
    else checks_passed++;
    $display("test_auto done: starts=%0d", start_cnt - base);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    bit ok;
    int t, base;
    base = start_cnt;
    set_resp(8'd5, 8'd6, 8'd7, 8'd8, 8'd26, 20);
    resp_bad_until = resp_attempt;
    wr_reg(3'd1, 32'd1);
    for (int i = 0; i < 3; i++) begin
      repeat (10) @(posedge clk);
      #1;
      wr_reg(3'd1, 32'd1);
    end
    wait_idle(400, ok, t);
    repeat (300) @(posedge clk);
    #1;
    exp_count = exp_count + 2;
    checks_total++;
    if (start_cnt - base !== 2) $display("FAIL b2b_starts: got %0d, want 2", start_cnt - base);
    else checks_passed++;
    rd_reg(3'd2, d);
    checks_total++;
    if (d[1] !== 1'b0) $display("FAIL b2b_busy: got %b, want 0", d[1]);
    else checks_passed++;
    rd_reg(3'd3, d);
    checks_total++;
    if (d !== 32'h05060708) $display("FAIL b2b_data: got 0x%08h, want 0x05060708", d);
    else checks_passed++;
    rd_reg(3'd5, d);
    checks_total++;
    if (d !== 32'(exp_count)) $display("FAIL b2b_count: got %0d, want %0d", d, exp_count);
    else checks_passed++;
    $display("test_back_to_back done: starts=%0d", start_cnt - base);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    bit ok;
    int t, base, lim, w_cyc;
    resp_delay = 0;
    wr_reg(3'd4, 32'd55);
    wr_reg(3'd0, 32'd2);
    base = start_cnt;
    wr_reg(3'd1, 32'd1);
    lim = 0;
    while (start_cnt == base && lim < 20) begin
      @(posedge clk); #1;
      lim++;
    end
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_count = 0;
    for (int w = 0; w < 6; w++) begin
      rd_reg(3'(w), d);
      checks_total++;
      if (d !== 32'd0) $display("FAIL rstmid_reg%0d: got 0x%08h, want 0", w, d);
      else checks_passed++;
    end
    checks_total++;
    if (irq !== 1'b0) $display("FAIL rstmid_irq: got %b, want 0", irq);
    else checks_passed++;
    set_resp(8'd40, 8'd0, 8'd25, 8'd3, 8'd68, 20);
    resp_bad_until = resp_attempt;
    base = start_cnt;
    wr_reg(3'd1, 32'd1);
    w_cyc = cyc;
    repeat (4) @(posedge clk);
    #1;
    checks_total++;
    if (start_cnt - base !== 1 || start_cyc[base] - w_cyc !== 2)
      $display("FAIL rstmid_start_latency: starts=%0d delay=%0d, want 1 start 2 cycles after CMD",
               start_cnt - base, start_cyc[base] - w_cyc);
    else checks_passed++;
    wait_idle(400, ok, t);
    exp_count = exp_count + 1;
    rd_reg(3'd5, d);
    checks_total++;
    if (!ok || d !== 32'(exp_count)) $display("FAIL rstmid_count: idle=%b count=%0d, want 1/%0d", ok, d, exp_count);
    else checks_passed++;
    $display("test_reset_mid done");
  endtask

  task automatic test_pulse_width();
    checks_total++;
    if (long_pulse !== 0) $display("FAIL start_pulse_width: %0d multi-cycle pulses, want 0", long_pulse);
    else checks_passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_irq();
    test_retry_cksum();
    test_timeout();
    test_auto();
    test_back_to_back();
    test_reset_mid();
    test_pulse_width();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
